one_to_two_demux: RTL and testbench
===================================

# one_to_two_demux

Sequential 1-to-2 stream demultiplexer: the distribution counterpart of the `Two_to_one_MUX`. Each accepted input beat is steered by `sel` into one of two independent per-lane FIFOs. Each lane drains through its own valid/ready output port. It sits between a single producer (datapath result bus) and two consumers, absorbing per-lane backpressure without cross-lane blocking of already-buffered data.

## Interface
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 4: entries per lane FIFO; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: producer has a beat.
- `in_ready` output 1: the lane selected by `sel` can accept.
- `in_data` input WIDTH: input payload.
- `sel` input 1: destination lane for the current beat; 0 = A, 1 = B. Sampled with `in_data`.
- `A_valid` output 1: lane A head valid.
- `A_ready` input 1: lane A consumer accepts.
- `A` output WIDTH: lane A head data.
- `B_valid` output 1: lane B head valid.
- `B_ready` input 1: lane B consumer accepts.
- `B` output WIDTH: lane B head data.
- `A_count` output $clog2(DEPTH+1): lane A occupancy.
- `B_count` output $clog2(DEPTH+1): lane B occupancy.

## Operation
- Push: on `in_valid && in_ready`, `in_data` is written to the tail of lane `sel`. The other lane is untouched.
- `in_ready` = !full(lane `sel`). It is combinational from `sel` and the registered occupancy only, never from `A_ready` or `B_ready`.
- Pop: on `A_valid && A_ready`, the lane A head is removed. Lane B behaves the same with its own signals. Both lanes may pop in the same cycle.
- `X_valid` = (count_X != 0). `A` and `B` present the head entry and are held stable while valid and not accepted.
- Ordering: FIFO order is preserved within each lane. There is no ordering relation across lanes.
- Simultaneous push and pop on the same lane:
  - Count is unchanged.
  - This is legal when the lane is full: the pop frees a slot but `in_ready` stays 0 that cycle. There is no pass-through.
- Empty lane: a beat is never bypassed to the output.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately and saturates by construction, since overflow and underflow are impossible under the handshake rules.
- Producer protocol: the producer may change `sel`/`in_data` while `in_ready` = 0. The block holds no state about unaccepted beats.

## Timing
- Latency: a beat pushed in cycle N appears as `X_valid` = 1 in cycle N+1 when the lane was empty.
- Throughput: one push per cycle plus one pop per lane per cycle.
- Reset (async assert, sync-safe deassert by the system):
  - `A_valid`, `B_valid` = 0.
  - `A_count`, `B_count` = 0.
  - `A`, `B` = 0, so storage is cleared to zero.
  - `in_ready` = 1.
- Reset asserted mid-stream discards all buffered beats immediately, without waiting for a clock edge.
- `A_count`/`B_count` update on the clock edge following the handshake.

## Structure
- Package `demux_pkg`: constants `LANE_A` = 1'b0 and `LANE_B` = 1'b1, plus a function returning count width for a given DEPTH.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; ports clk, rst_n, push, push_data, full, pop, head, empty, count), instantiated twice.
- Top level contains only the steering logic: push enables gated by `sel`, and `in_ready` mux.

## Test plan
- Reset then idle: after `rst_n` 0→1 → `A_valid` = `B_valid` = 0, counts 0, `in_ready` = 1, `A` = `B` = 0.
- Steering: push 0x11 (sel=0), 0x22 (sel=1), 0x33 (sel=0) with both readies 0 → `A_count` = 2, `B_count` = 1. Then raise both readies → A yields 0x11, 0x33 and B yields 0x22.
- Full lane A: `A_ready` = 0, push 4 beats sel=0 → `A_count` = 4 and `in_ready` = 0 while sel=0. Switching sel=1 → `in_ready` = 1 and a B push of 0xBB succeeds.
- Full plus simultaneous pop: lane A full, `A_ready` = 1 and `in_valid` = 1, sel=0 → no push that cycle and `A_count` = 3 next cycle. A push the following cycle is accepted.
- Wrap-around: stream 0x00..0x0F continuously into lane B with `B_ready` = 1 → output order is exact, `B_count` ≤ 1 throughout, and pointers wrap 4 times.
- Mid-operation reset: lane A at count 3, assert `rst_n` = 0 between edges → `A_valid` and count drop to 0 without a clock edge. After release, first push 0x5A emerges as first A output.

Source files
------------

// File: rtl/one_to_two_demux_pkg.sv
// Shared lane encodings and sizing helpers for the 1-to-2 stream demultiplexer.
package demux_pkg;

   localparam logic LANE_A = 1'b0;
   localparam logic LANE_B = 1'b1;

   // Occupancy counters must represent 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth + 32'sd1);
   endfunction

endpackage

// File: rtl/one_to_two_demux_sync_fifo.sv
// Single-clock FIFO with separate occupancy count; storage is cleared on reset so the
// head reads zero until the first write lands.
module sync_fifo
   import demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   output logic                          full,
   input  logic                          pop,
   output logic [WIDTH-1:0]              head,
   output logic                          empty,
   output logic [count_width(DEPTH)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign head      = mem_r[rd_ptr_r];
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;

   // Storage, pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/one_to_two_demux.sv
// Steers each accepted input beat into lane A or B by sel; each lane buffers and drains
// independently so backpressure on one lane never stalls already-buffered data on the other.
module one_to_two_demux
   import demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   input  logic                          sel,
   output logic                          A_valid,
   input  logic                          A_ready,
   output logic [WIDTH-1:0]              A,
   output logic                          B_valid,
   input  logic                          B_ready,
   output logic [WIDTH-1:0]              B,
   output logic [count_width(DEPTH)-1:0] A_count,
   output logic [count_width(DEPTH)-1:0] B_count
);

   logic push_a_s;
   logic push_b_s;
   logic full_a_s;
   logic full_b_s;
   logic empty_a_s;
   logic empty_b_s;

   // Ready depends only on the selected lane's registered fullness, never on downstream ready.
   always_comb begin
      in_ready = 1'b0;
      push_a_s = 1'b0;
      push_b_s = 1'b0;
      if (sel == LANE_B) begin
         in_ready = !full_b_s;
         push_b_s = in_valid && !full_b_s;
      end else begin
         in_ready = !full_a_s;
         push_a_s = in_valid && !full_a_s;
      end
   end

   assign A_valid = !empty_a_s;
   assign B_valid = !empty_b_s;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_a_s),
      .push_data (in_data),
      .full      (full_a_s),
      .pop       (A_ready),
      .head      (A),
      .empty     (empty_a_s),
      .count     (A_count)
   );

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_b_s),
      .push_data (in_data),
      .full      (full_b_s),
      .pop       (B_ready),
      .head      (B),
      .empty     (empty_b_s),
      .count     (B_count)
   );

endmodule

// File: tb/tb_one_to_two_demux.sv
// Self-checking bench for one_to_two_demux: vector table, directed corner sequences and a
// randomized run against a queue-based lane model.
module tb_one_to_two_demux;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             sel;
   logic             A_valid;
   logic             A_ready;
   logic [WIDTH-1:0] A;
   logic             B_valid;
   logic             B_ready;
   logic [WIDTH-1:0] B;
   logic [CW-1:0]    A_count;
   logic [CW-1:0]    B_count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   one_to_two_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .sel      (sel),
      .A_valid  (A_valid),
      .A_ready  (A_ready),
      .A        (A),
      .B_valid  (B_valid),
      .B_ready  (B_ready),
      .B        (B),
      .A_count  (A_count),
      .B_count  (B_count)
   );

   typedef struct {
      logic       iv;
      logic       s;
      logic [7:0] d;
      logic       ar;
      logic       br;
      logic       ir;
      logic       av;
      logic [7:0] a;
      logic       bv;
      logic [7:0] b;
      int         ac;
      int         bc;
   } vec_t;

   vec_t tbl [7];
   logic [7:0] qa [$];
   logic [7:0] qb [$];
   logic [7:0] exp_drain [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic iv, input logic s, input logic [7:0] d,
                        input logic ar, input logic br);
      in_valid = iv;
      sel      = s;
      in_data  = d;
      A_ready  = ar;
      B_ready  = br;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic       r_iv, r_sel, r_ar, r_br, exp_ir;
      logic [7:0] r_d;
      int         exp_next;

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mid();
      chk("reset_a_valid", A_valid, 1'b0);
      chk("reset_b_valid", B_valid, 1'b0);
      chk("reset_a_count", A_count, 0);
      chk("reset_b_count", B_count, 0);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_a_data", A, 8'h00);
      chk("reset_b_data", B, 8'h00);
      tick();

      // Steering: 0x11->A, 0x22->B, 0x33->A, then drain both lanes.
      tbl[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 0, 0};
      tbl[1] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1, 0};
      tbl[2] = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1, 1};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 2, 1};
      tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 2, 1};
      tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1, 0};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 0, 0};
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].iv, tbl[i].s, tbl[i].d, tbl[i].ar, tbl[i].br);
         mid();
         chk("tbl_in_ready", in_ready, tbl[i].ir);
         chk("tbl_a_valid", A_valid, tbl[i].av);
         chk("tbl_b_valid", B_valid, tbl[i].bv);
         chk("tbl_a_count", A_count, tbl[i].ac);
         chk("tbl_b_count", B_count, tbl[i].bc);
         if (tbl[i].av) chk("tbl_a_data", A, tbl[i].a);
         if (tbl[i].bv) chk("tbl_b_data", B, tbl[i].b);
         tick();
      end

      // Fill lane A, then check per-lane ready and a B push while A is full.
      for (int c = 0; c < DEPTH; c++) begin
         drive(1'b1, 1'b0, 8'hA0 + 8'(c), 1'b0, 1'b0);
         mid();
         chk("fill_in_ready", in_ready, 1'b1);
         tick();
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      mid();
      chk("full_a_count", A_count, 4);
      chk("full_in_ready_sel0", in_ready, 1'b0);
      drive(1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
      #1;
      chk("full_in_ready_sel1", in_ready, 1'b1);
      tick();
      mid();
      chk("b_push_count", B_count, 1);
      chk("b_push_data", B, 8'hBB);

      // Full lane A with simultaneous pop: no push accepted that cycle.
      drive(1'b1, 1'b0, 8'hCC, 1'b1, 1'b0);
      #1;
      chk("fullpop_in_ready", in_ready, 1'b0);
      tick();
      mid();
      chk("fullpop_a_count", A_count, 3);
      chk("fullpop_a_head", A, 8'hA1);
      drive(1'b1, 1'b0, 8'hDD, 1'b0, 1'b0);
      #1;
      chk("after_pop_in_ready", in_ready, 1'b1);
      tick();
      mid();
      chk("after_pop_a_count", A_count, 4);
      exp_drain = '{8'hA1, 8'hA2, 8'hA3, 8'hDD};
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
         #1;
         chk("drain_a_data", A, exp_drain[k]);
         if (k == 0) chk("drain_b_data", B, 8'hBB);
         tick();
         mid();
      end
      chk("drain_a_count", A_count, 0);
      chk("drain_b_count", B_count, 0);
      tick();

      // Wrap-around: 16 back-to-back beats through lane B.
      exp_next = 0;
      for (int c = 0; c < 18; c++) begin
         drive(c < 16, 1'b1, 8'(c), 1'b0, 1'b1);
         mid();
         chk("wrap_count_le1", B_count <= CW'(1), 1'b1);
         if (B_valid) begin
            chk("wrap_order", B, 8'(exp_next));
            exp_next++;
         end
         tick();
      end
      chk("wrap_total", exp_next, 16);

      // Mid-operation reset drops buffered beats without a clock edge.
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b0, 8'h70 + 8'(c), 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      mid();
      chk("pre_rst_a_count", A_count, 3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_a_valid", A_valid, 1'b0);
      chk("async_rst_a_count", A_count, 0);
      #1;
      rst_n = 1'b1;
      tick();
      drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
      mid();
      chk("post_rst_in_ready", in_ready, 1'b1);
      tick();
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      mid();
      chk("post_rst_a_valid", A_valid, 1'b1);
      chk("post_rst_a_data", A, 8'h5A);
      chk("post_rst_a_count", A_count, 1);

      // Clean restart for the randomized run.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < 400; c++) begin
         r_iv  = ($urandom_range(0, 3) != 0);
         r_sel = 1'($urandom_range(0, 1));
         r_d   = 8'($urandom);
         r_ar  = ($urandom_range(0, 2) == 0);
         r_br  = ($urandom_range(0, 1) == 0);
         drive(r_iv, r_sel, r_d, r_ar, r_br);
         mid();
         exp_ir = r_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
         chk("rnd_in_ready", in_ready, exp_ir);
         chk("rnd_a_valid", A_valid, qa.size() != 0);
         chk("rnd_b_valid", B_valid, qb.size() != 0);
         chk("rnd_a_count", A_count, qa.size());
         chk("rnd_b_count", B_count, qb.size());
         if (qa.size() != 0) chk("rnd_a_data", A, qa[0]);
         if (qb.size() != 0) chk("rnd_b_data", B, qb[0]);
         if (r_ar && qa.size() != 0) void'(qa.pop_front());
         if (r_br && qb.size() != 0) void'(qb.pop_front());
         if (r_iv && exp_ir) begin
            if (r_sel) qb.push_back(r_d);
            else qa.push_back(r_d);
         end
         tick();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
